multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle successor of the single-cycle RV decoder/control unit for npc.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Uses valid/done handshakes to IFU, LSU and an optional multi-cycle MDU.
//  Parametrised for RV32/RV64 and the optional M extension.
//  Adds a bus timeout and sticky HALT/TRAP states.
// PARAMETERS
//  XLEN      32   32 or 64; 64 enables OP-IMM-32/OP-32 and LD/SD/LWU.
//  EN_M      0    1 = OP/OP-32 with funct7=0000001 legal, executed on the MDU.
//  TIMEOUT   255  max wait cycles in FETCH or MEM before TRAP; 0 disables.
//  TO_W      8    timeout counter width; must satisfy TIMEOUT < 2**TO_W.
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous reset, active-low
//  ifu_req      out  1   instruction fetch request, held until ifu_rvalid
//  ifu_rvalid   in   1   fetch data valid
//  inst         in   32  fetched instruction, sampled when ifu_rvalid=1
//  lsu_req      out  1   memory access request, held until lsu_done
//  lsu_we       out  1   1=store, 0=load; valid while lsu_req=1
//  lsu_done     in   1   memory access complete
//  mdu_start    out  1   1-cycle pulse launching a mul/div
//  mdu_done     in   1   mul/div result ready
//  br_taken     in   1   ALU branch-compare result, valid in EXEC
//  en_Wreg      out  1   register-file write enable (WB only)
//  wb_sel       out  2   00 ALU, 01 MEM, 10 PC+4, 11 MDU
//  pc_we        out  1   PC update strobe (WB only)
//  pc_sel       out  1   0 = PC+4, 1 = branch/jump target
//  retire       out  1   1-cycle pulse per completed instruction
//  halted       out  1   sticky; ebreak executed
//  trap         out  1   sticky; illegal instruction or timeout
//  trap_cause   out  2   01 illegal, 10 fetch timeout, 11 mem timeout
//  state        out  3   current FSM state (debug)
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
//  Reset: state=FETCH; IR=0; taken_q=0; timeout counter=0; halted=trap=0; trap_cause=0.
//  Reset mid-operation aborts the instruction; no partial WB occurs.
//  Outputs are Moore-decoded from state plus registered decode fields.
//  FETCH: ifu_req=1.
//   - ifu_rvalid=1: IR<=inst, go DECODE.
//   - Otherwise count wait cycles; wait count reaching TIMEOUT goes to TRAP with cause 10.
//  DECODE (1 cycle):
//   - ebreak (0x00100073) -> HALT.
//   - Unknown opcode, or an XLEN/EN_M-gated encoding while disabled -> TRAP with cause 01.
//   - Otherwise -> EXEC.
//  EXEC:
//   - Non-M: 1 cycle. On exit, latch taken_q = jal|jalr|(branch & br_taken).
//   - M op: mdu_start=1 on the entry cycle only; stay in EXEC until mdu_done.
//     No timeout applies here.
//   - Next state: load/store -> MEM; otherwise -> WB.
//  MEM: lsu_req=1, lsu_we=store.
//   - lsu_done -> WB.
//   - Wait count reaching TIMEOUT -> TRAP with cause 11.
//   - A store in MEM writes no register.
//  WB (1 cycle): pc_we=1, pc_sel=taken_q, retire=1; then -> FETCH.
//   - en_Wreg=1 for R, I, load, jal, jalr, lui, auipc, M ops; 0 for store, branch, rd==0.
//   - wb_sel: load=01, jal/jalr=10, M=11, else 00.
//  HALT and TRAP: absorbing until reset. All request, strobe and write outputs are 0.
//  Timeout counter clears on every state entry; it saturates and never wraps.
//  A done/valid arriving in the same cycle the count hits TIMEOUT wins (no trap).
//  Stray ifu_rvalid, lsu_done or mdu_done outside its own wait state is ignored.
//  CPI: ALU/branch 4 cycles; load/store 4+mem; M ops 4+mdu latency (0-wait handshakes).
// TESTING
//  1 addi x1,x0,5; ifu_rvalid 1st cycle -> states 0,1,2,4; WB: en_Wreg=1, wb_sel=00, pc_sel=0, retire.
//  2 lw, lsu_done after 3 cycles -> lsu_req high 4 cycles, lsu_we=0; WB: wb_sel=01, en_Wreg=1.
//  3 beq with br_taken=1 -> WB: pc_sel=1, en_Wreg=0; sw -> en_Wreg=0, lsu_we=1.
//  4 XLEN=32: ld (0x0000B083) -> TRAP, cause 01; XLEN=64 with EN_M=1: mulw -> one mdu_start, wb_sel=11.
//  5 TIMEOUT=4, ifu_rvalid never -> TRAP cause 10 after 4 wait cycles; rvalid on 4th cycle -> no trap.
//  6 ebreak -> halted=1 held 100 cycles, no ifu_req; rst_n low mid-MEM -> state=0 next edge-free.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Handshake bundle between the multi-cycle control FSM and the
//               instruction fetch unit, load/store unit and mul/div unit.
//               master : controller side (drives requests, receives dones)
//               slave  : unit side (receives requests, drives dones)
//               Signals:
//                 ifu_req / ifu_rvalid / inst      fetch handshake + data
//                 lsu_req / lsu_we / lsu_done      memory access handshake
//                 mdu_start / mdu_done             mul/div launch + completion
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic        ifu_req;
    logic        ifu_rvalid;
    logic [31:0] inst;
    logic        lsu_req;
    logic        lsu_we;
    logic        lsu_done;
    logic        mdu_start;
    logic        mdu_done;

    modport master (
        output ifu_req,
        output lsu_req,
        output lsu_we,
        output mdu_start,
        input  ifu_rvalid,
        input  inst,
        input  lsu_done,
        input  mdu_done
    );

    modport slave (
        input  ifu_req,
        input  lsu_req,
        input  lsu_we,
        input  mdu_start,
        output ifu_rvalid,
        output inst,
        output lsu_done,
        output mdu_done
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Multi-cycle RISC-V control unit. Sequences every instruction
//               through FETCH/DECODE/EXEC/MEM/WB using valid/done handshakes
//               to the IFU, LSU and an optional multi-cycle MDU. Supports
//               RV32/RV64 and the optional M extension, a wait-cycle bus
//               timeout, and sticky HALT (ebreak) / TRAP states.
//               Ports:
//                 clk, rst_n    clock, asynchronous active-low reset
//                 bus           IFU/LSU/MDU handshakes (master modport)
//                 br_taken      branch compare result, sampled in EXEC
//                 en_Wreg       register write enable (WB only)
//                 wb_sel        00 ALU, 01 MEM, 10 PC+4, 11 MDU
//                 pc_we, pc_sel PC update strobe and target select
//                 retire        one pulse per completed instruction
//                 halted, trap  sticky status flags
//                 trap_cause    01 illegal, 10 fetch timeout, 11 mem timeout
//                 state         current FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
    parameter int XLEN    = 32,
    parameter int EN_M    = 0,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    multicycle_ctrl_if.master      bus,
    input  wire logic              br_taken,
    output logic                   en_Wreg,
    output logic [1:0]             wb_sel,
    output logic                   pc_we,
    output logic                   pc_sel,
    output logic                   retire,
    output logic                   halted,
    output logic                   trap,
    output logic [1:0]             trap_cause,
    output logic [2:0]             state
);

    localparam bit               c_RV64    = (XLEN == 64);
    localparam bit               c_HAS_M   = (EN_M != 0);
    localparam bit               c_TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0]  c_TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [31:0]      c_EBREAK  = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_ir;
    logic            r_taken;
    logic [TO_W-1:0] r_cnt;
    logic            r_halted;
    logic            r_trap;
    logic [1:0]      r_trap_cause;
    logic [1:0]      w_trap_cause;
    logic            r_exec_first;

    // Decode fields captured when leaving DECODE.
    logic            r_is_load;
    logic            r_is_store;
    logic            r_is_branch;
    logic            r_is_jump;
    logic            r_is_m;
    logic            r_wen;
    logic [1:0]      r_wb_sel;

    // Combinational decode of IR.
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic            w_legal;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_branch;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_is_m;
    logic            w_writes;
    logic            w_is_ebreak;
    logic            w_to_hit;

    assign w_opcode    = r_ir[6:0];
    assign w_funct3    = r_ir[14:12];
    assign w_funct7    = r_ir[31:25];
    assign w_rd        = r_ir[11:7];
    assign w_is_ebreak = (r_ir == c_EBREAK);

    // ------------------------------------------------------------------------
    // Instruction legality and class decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_legal     = 1'b0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_is_jalr   = 1'b0;
        w_is_m      = 1'b0;
        w_writes    = 1'b0;
        case (w_opcode)
            7'b0110111, 7'b0010111: begin   // lui, auipc
                w_legal  = 1'b1;
                w_writes = 1'b1;
            end
            7'b1101111: begin               // jal
                w_legal  = 1'b1;
                w_is_jal = 1'b1;
                w_writes = 1'b1;
            end
            7'b1100111: begin               // jalr
                w_legal   = (w_funct3 == 3'b000);
                w_is_jalr = 1'b1;
                w_writes  = 1'b1;
            end
            7'b1100011: begin               // branches; funct3 010/011 unused
                w_legal     = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
                w_is_branch = 1'b1;
            end
            7'b0000011: begin               // loads; ld/lwu only on RV64
                w_is_load = 1'b1;
                w_writes  = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001, 3'b010,
                    3'b100, 3'b101:         w_legal = 1'b1;
                    3'b011, 3'b110:         w_legal = c_RV64;
                    default:                w_legal = 1'b0;
                endcase
            end
            7'b0100011: begin               // stores; sd only on RV64
                w_is_store = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                    3'b011:                 w_legal = c_RV64;
                    default:                w_legal = 1'b0;
                endcase
            end
            7'b0010011: begin               // OP-IMM; RV64 shifts use funct7[0] as shamt[5]
                w_writes = 1'b1;
                case (w_funct3)
                    3'b001:  w_legal = c_RV64 ? (w_funct7[6:1] == 6'b000000)
                                              : (w_funct7 == 7'b0000000);
                    3'b101:  w_legal = c_RV64 ? ((w_funct7[6:1] == 6'b000000) ||
                                                 (w_funct7[6:1] == 6'b010000))
                                              : ((w_funct7 == 7'b0000000) ||
                                                 (w_funct7 == 7'b0100000));
                    default: w_legal = 1'b1;
                endcase
            end
            7'b0110011: begin               // OP
                w_writes = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    w_legal = 1'b1;
                end else if (w_funct7 == 7'b0100000) begin
                    w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
                end else if (w_funct7 == 7'b0000001) begin
                    w_legal = c_HAS_M;
                    w_is_m  = 1'b1;
                end
            end
            7'b0011011: begin               // OP-IMM-32
                w_writes = 1'b1;
                case (w_funct3)
                    3'b000:  w_legal = c_RV64;
                    3'b001:  w_legal = c_RV64 && (w_funct7 == 7'b0000000);
                    3'b101:  w_legal = c_RV64 && ((w_funct7 == 7'b0000000) ||
                                                  (w_funct7 == 7'b0100000));
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0111011: begin               // OP-32
                w_writes = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    w_legal = c_RV64 && ((w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                                         (w_funct3 == 3'b101));
                end else if (w_funct7 == 7'b0100000) begin
                    w_legal = c_RV64 && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101));
                end else if (w_funct7 == 7'b0000001) begin
                    w_legal = c_RV64 && c_HAS_M && (w_funct3 != 3'b001) &&
                              (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
                    w_is_m  = 1'b1;
                end
            end
            7'b0001111: begin               // fence: retires as a no-op
                w_legal = 1'b1;
            end
            default: begin                  // SYSTEM other than ebreak, unknown opcodes
                w_legal = 1'b0;
            end
        endcase
    end

    // Wait count reaches TIMEOUT on this cycle if no handshake arrives.
    assign w_to_hit = c_TO_EN && (r_cnt == c_TO_LAST);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        w_trap_cause = 2'b00;
        case (r_state)
            S_FETCH: begin
                if (bus.ifu_rvalid) begin
                    w_next = S_DECODE;
                end else if (w_to_hit) begin
                    w_next       = S_TRAP;
                    w_trap_cause = 2'b10;
                end
            end
            S_DECODE: begin
                if (w_is_ebreak) begin
                    w_next = S_HALT;
                end else if (!w_legal) begin
                    w_next       = S_TRAP;
                    w_trap_cause = 2'b01;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!r_is_m || bus.mdu_done) begin
                    w_next = (r_is_load || r_is_store) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                if (bus.lsu_done) begin
                    w_next = S_WB;
                end else if (w_to_hit) begin
                    w_next       = S_TRAP;
                    w_trap_cause = 2'b11;
                end
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath-control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_ir         <= 32'h0;
            r_taken      <= 1'b0;
            r_cnt        <= '0;
            r_halted     <= 1'b0;
            r_trap       <= 1'b0;
            r_trap_cause <= 2'b00;
            r_exec_first <= 1'b0;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_is_branch  <= 1'b0;
            r_is_jump    <= 1'b0;
            r_is_m       <= 1'b0;
            r_wen        <= 1'b0;
            r_wb_sel     <= 2'b00;
        end else begin
            r_state <= w_next;

            if (r_state == S_FETCH && bus.ifu_rvalid) begin
                r_ir <= bus.inst;
            end

            if (r_state == S_DECODE) begin
                r_is_load   <= w_is_load;
                r_is_store  <= w_is_store;
                r_is_branch <= w_is_branch;
                r_is_jump   <= w_is_jal || w_is_jalr;
                r_is_m      <= w_is_m;
                r_wen       <= w_writes && (w_rd != 5'd0);
                r_wb_sel    <= w_is_load                ? 2'b01 :
                               (w_is_jal || w_is_jalr)  ? 2'b10 :
                               w_is_m                   ? 2'b11 : 2'b00;
            end

            // Only the DECODE->EXEC transition marks the mdu_start cycle.
            r_exec_first <= (r_state == S_DECODE) && (w_next == S_EXEC);

            if (r_state == S_EXEC && w_next != S_EXEC) begin
                r_taken <= r_is_jump || (r_is_branch && br_taken);
            end

            // Cleared on any state change; saturating count while waiting.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_FETCH || r_state == S_MEM) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_next == S_HALT && r_state != S_HALT) begin
                r_halted <= 1'b1;
            end

            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_trap_cause;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------------
    always_comb begin
        bus.ifu_req   = (r_state == S_FETCH);
        bus.lsu_req   = (r_state == S_MEM);
        bus.lsu_we    = (r_state == S_MEM) && r_is_store;
        bus.mdu_start = (r_state == S_EXEC) && r_is_m && r_exec_first;
        en_Wreg       = (r_state == S_WB) && r_wen;
        pc_we         = (r_state == S_WB);
        retire        = (r_state == S_WB);
        pc_sel        = r_taken;
        wb_sel        = r_wb_sel;
    end

    assign halted     = r_halted;
    assign trap       = r_trap;
    assign trap_cause = r_trap_cause;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl_fsm
// Description : Self-checking bench for multicycle_ctrl_fsm. Two instances
//               (RV32 no-M with TIMEOUT=4, RV64+M with timeout disabled) share
//               the same stimulus; one is observed at a time. A vector table
//               drives whole instructions, a scoreboard checks the WB fields
//               at each retire, and hand sequences cover traps, timeouts,
//               halt and reset mid-access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_rvalid, lsu_done, mdu_done, br_taken;
    logic [31:0] inst;
    bit          use64;

    always #5 clk = ~clk;

    multicycle_ctrl_if if32 ();
    multicycle_ctrl_if if64 ();

    assign if32.ifu_rvalid = ifu_rvalid;
    assign if32.inst       = inst;
    assign if32.lsu_done   = lsu_done;
    assign if32.mdu_done   = mdu_done;
    assign if64.ifu_rvalid = ifu_rvalid;
    assign if64.inst       = inst;
    assign if64.lsu_done   = lsu_done;
    assign if64.mdu_done   = mdu_done;

    logic       en32, en64, pcwe32, pcwe64, pcsel32, pcsel64;
    logic       ret32, ret64, halt32, halt64, trap32, trap64;
    logic [1:0] sel32, sel64, cause32, cause64;
    logic [2:0] st32, st64;

    multicycle_ctrl_fsm #(.XLEN(32), .EN_M(0), .TIMEOUT(4), .TO_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(if32), .br_taken(br_taken),
        .en_Wreg(en32), .wb_sel(sel32), .pc_we(pcwe32), .pc_sel(pcsel32),
        .retire(ret32), .halted(halt32), .trap(trap32), .trap_cause(cause32),
        .state(st32)
    );

    multicycle_ctrl_fsm #(.XLEN(64), .EN_M(1), .TIMEOUT(0), .TO_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .bus(if64), .br_taken(br_taken),
        .en_Wreg(en64), .wb_sel(sel64), .pc_we(pcwe64), .pc_sel(pcsel64),
        .retire(ret64), .halted(halt64), .trap(trap64), .trap_cause(cause64),
        .state(st64)
    );

    // Observed instance
    logic       o_ifu_req, o_lsu_req, o_lsu_we, o_mdu_start;
    logic       o_en, o_pcwe, o_pcsel, o_retire, o_halted, o_trap;
    logic [1:0] o_sel, o_cause;
    logic [2:0] o_state;

    assign o_ifu_req   = use64 ? if64.ifu_req   : if32.ifu_req;
    assign o_lsu_req   = use64 ? if64.lsu_req   : if32.lsu_req;
    assign o_lsu_we    = use64 ? if64.lsu_we    : if32.lsu_we;
    assign o_mdu_start = use64 ? if64.mdu_start : if32.mdu_start;
    assign o_en        = use64 ? en64    : en32;
    assign o_pcwe      = use64 ? pcwe64  : pcwe32;
    assign o_pcsel     = use64 ? pcsel64 : pcsel32;
    assign o_retire    = use64 ? ret64   : ret32;
    assign o_halted    = use64 ? halt64  : halt32;
    assign o_trap      = use64 ? trap64  : trap32;
    assign o_sel       = use64 ? sel64   : sel32;
    assign o_cause     = use64 ? cause64 : cause32;
    assign o_state     = use64 ? st64    : st32;

    typedef struct {
        string       name;
        logic [31:0] inst;
        bit          br;
        int          mem_lat;   // -1: no memory phase
        bit          is_m;
        int          mdu_lat;
        bit          exp_we;
        bit          exp_wen;
        logic [1:0]  exp_sel;
        bit          exp_pcsel;
    } vec_t;

    typedef struct {
        string      name;
        bit         wen;
        logic [1:0] sel;
        bit         pcsel;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_retire = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected WB fields popped at each retire pulse.
    always @(negedge clk) begin
        if (rst_n && o_retire) begin
            exp_t e;
            n_retire++;
            if (sb.size() == 0) begin
                check("unexpected_retire", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_en_Wreg"}, {31'd0, o_en},    {31'd0, e.wen});
                check({e.name, "_wb_sel"},  {30'd0, o_sel},   {30'd0, e.sel});
                check({e.name, "_pc_sel"},  {31'd0, o_pcsel}, {31'd0, e.pcsel});
                check({e.name, "_pc_we"},   {31'd0, o_pcwe},  32'd1);
            end
        end
    end

    // Returns at a negedge in cycle 1 of FETCH with wait count 0.
    task automatic do_reset(input bit sel);
        use64      = sel;
        rst_n      = 1'b0;
        ifu_rvalid = 1'b0;
        lsu_done   = 1'b0;
        mdu_done   = 1'b0;
        br_taken   = 1'b0;
        inst       = 32'h0;
        repeat (2) @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc, mcyc, xcyc, starts, exp_cyc;
        bit   we_ok;
        exp_t e;
        check({v.name, "_start_state"}, {29'd0, o_state}, 32'd0);
        e.name = v.name; e.wen = v.exp_wen; e.sel = v.exp_sel; e.pcsel = v.exp_pcsel;
        sb.push_back(e);
        inst       = v.inst;
        ifu_rvalid = 1'b1;
        br_taken   = v.br;
        cyc = 0; mcyc = 0; xcyc = 0; starts = 0; we_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            ifu_rvalid = 1'b0;
            lsu_done   = 1'b0;
            mdu_done   = 1'b0;
            if (o_mdu_start) starts++;
            if (o_state == 3'd2 && v.is_m) begin
                xcyc++;
                if (xcyc == v.mdu_lat + 1) mdu_done = 1'b1;
            end
            if (o_lsu_req) begin
                mcyc++;
                if (o_lsu_we !== v.exp_we) we_ok = 1'b0;
                if (mcyc == v.mem_lat + 1) lsu_done = 1'b1;
            end
        end while (o_state != 3'd0 && cyc < 60);
        exp_cyc = 4 + ((v.mem_lat >= 0) ? v.mem_lat + 1 : 0) + (v.is_m ? v.mdu_lat : 0);
        check({v.name, "_cycles"}, cyc, exp_cyc);
        check({v.name, "_lsu_req_cycles"}, mcyc, (v.mem_lat >= 0) ? v.mem_lat + 1 : 0);
        check({v.name, "_mdu_starts"}, starts, v.is_m ? 1 : 0);
        if (v.mem_lat >= 0) check({v.name, "_lsu_we"}, {31'd0, we_ok}, 32'd1);
        br_taken = 1'b0;
    endtask

    task automatic trap_inst(input string name, input logic [31:0] ins);
        do_reset(1'b0);
        inst = ins;
        ifu_rvalid = 1'b1;
        @(negedge clk);
        ifu_rvalid = 1'b0;
        check({name, "_decode"}, {29'd0, o_state}, 32'd1);
        @(negedge clk);
        check({name, "_state"}, {29'd0, o_state}, 32'd6);
        check({name, "_trap"},  {31'd0, o_trap},  32'd1);
        check({name, "_cause"}, {30'd0, o_cause}, 32'd1);
        check({name, "_ifu_req"}, {31'd0, o_ifu_req}, 32'd0);
    endtask

    vec_t tbl[$];
    vec_t addi_v;

    initial begin
        int bad, r0, w;
        vec_t v;

        //        name          inst          br  mem  m  mdu we wen sel    pcsel
        tbl.push_back('{"addi",   32'h0050_0093, 0, -1, 0, 0, 0, 1, 2'b00, 0});
        tbl.push_back('{"lw",     32'h0001_2083, 0,  3, 0, 0, 0, 1, 2'b01, 0});
        tbl.push_back('{"beq_t",  32'h0000_0463, 1, -1, 0, 0, 0, 0, 2'b00, 1});
        tbl.push_back('{"beq_nt", 32'h0000_0463, 0, -1, 0, 0, 0, 0, 2'b00, 0});
        tbl.push_back('{"sw",     32'h0011_2023, 0,  0, 0, 0, 1, 0, 2'b00, 0});
        tbl.push_back('{"jal",    32'h0100_00EF, 0, -1, 0, 0, 0, 1, 2'b10, 1});
        tbl.push_back('{"jalr_x0",32'h0000_8067, 0, -1, 0, 0, 0, 0, 2'b10, 1});
        tbl.push_back('{"lui",    32'h1234_52B7, 0, -1, 0, 0, 0, 1, 2'b00, 0});
        tbl.push_back('{"add",    32'h0020_81B3, 0, -1, 0, 0, 0, 1, 2'b00, 0});
        tbl.push_back('{"nop",    32'h0000_0013, 0, -1, 0, 0, 0, 0, 2'b00, 0});
        tbl.push_back('{"lbu",    32'h0001_4203, 0,  1, 0, 0, 0, 1, 2'b01, 0});
        addi_v = tbl[0];

        // Reset state
        use64 = 1'b0; rst_n = 1'b0;
        ifu_rvalid = 1'b0; lsu_done = 1'b0; mdu_done = 1'b0; br_taken = 1'b0; inst = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_state",   {29'd0, o_state},  32'd0);
        check("rst_trap",    {31'd0, o_trap},   32'd0);
        check("rst_halted",  {31'd0, o_halted}, 32'd0);
        check("rst_cause",   {30'd0, o_cause},  32'd0);
        check("rst_retire",  {31'd0, o_retire}, 32'd0);
        check("rst_pc_sel",  {31'd0, o_pcsel},  32'd0);

        // Table-driven instruction stream on the RV32 instance
        do_reset(1'b0);
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);
        check("sb_drained", sb.size(), 0);

        // Illegal encodings on RV32 without M
        trap_inst("ld_rv32",  32'h0000_B083);
        trap_inst("mul_noM",  32'h0220_81B3);

        // Fetch timeout: four wait cycles then TRAP
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        check("fto_still_fetch", {29'd0, o_state}, 32'd0);
        @(negedge clk);
        check("fto_state", {29'd0, o_state}, 32'd6);
        check("fto_cause", {30'd0, o_cause}, 32'd2);

        // rvalid on the 4th wait cycle wins
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        addi_v.name = "addi_late";
        run_vec(addi_v);
        check("late_no_trap", {31'd0, o_trap}, 32'd0);

        // MEM timeout: lsu_done never arrives
        do_reset(1'b0);
        inst = 32'h0001_2083; ifu_rvalid = 1'b1;
        @(negedge clk);
        ifu_rvalid = 1'b0;
        w = 0;
        while (!o_lsu_req && w < 10) begin @(negedge clk); w++; end
        check("mto_reached_mem", {29'd0, o_state}, 32'd3);
        repeat (3) @(negedge clk);
        check("mto_still_mem", {29'd0, o_state}, 32'd3);
        @(negedge clk);
        check("mto_state", {29'd0, o_state}, 32'd6);
        check("mto_cause", {30'd0, o_cause}, 32'd3);
        check("mto_lsu_req", {31'd0, o_lsu_req}, 32'd0);

        // ebreak: sticky HALT with every request/strobe low
        do_reset(1'b0);
        inst = 32'h0010_0073; ifu_rvalid = 1'b1;
        @(negedge clk);
        ifu_rvalid = 1'b0;
        @(negedge clk);
        check("halt_state", {29'd0, o_state}, 32'd5);
        bad = 0;
        lsu_done = 1'b1; mdu_done = 1'b1; ifu_rvalid = 1'b1;  // stray handshakes
        repeat (100) begin
            @(negedge clk);
            if (!o_halted || o_ifu_req || o_lsu_req || o_retire || o_pcwe ||
                o_en || o_trap || o_mdu_start || o_state != 3'd5) bad++;
        end
        lsu_done = 1'b0; mdu_done = 1'b0; ifu_rvalid = 1'b0;
        check("halt_hold_bad_cycles", bad, 0);

        // Reset asserted mid-MEM aborts without a retire
        do_reset(1'b0);
        inst = 32'h0001_2083; ifu_rvalid = 1'b1;
        @(negedge clk);
        ifu_rvalid = 1'b0;
        w = 0;
        while (!o_lsu_req && w < 10) begin @(negedge clk); w++; end
        @(negedge clk);
        check("abort_in_mem", {29'd0, o_state}, 32'd3);
        r0 = n_retire;
        rst_n = 1'b0;
        #1;
        check("abort_async_state", {29'd0, o_state}, 32'd0);
        check("abort_lsu_req", {31'd0, o_lsu_req}, 32'd0);
        repeat (2) @(negedge clk);
        check("abort_no_retire", n_retire, r0);

        // RV64 + M instance
        do_reset(1'b1);
        v = '{"mulw",   32'h0231_00BB, 0, -1, 1, 3, 0, 1, 2'b11, 0}; run_vec(v);
        v = '{"mulw_0", 32'h0231_00BB, 0, -1, 1, 0, 0, 1, 2'b11, 0}; run_vec(v);
        v = '{"ld64",   32'h0000_B083, 0,  1, 0, 0, 0, 1, 2'b01, 0}; run_vec(v);
        v = '{"sd64",   32'h0011_3023, 0,  2, 0, 0, 1, 0, 2'b00, 0}; run_vec(v);
        check("rv64_no_trap", {31'd0, o_trap}, 32'd0);
        check("sb_drained_64", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
